// File: rtl/player_pkg.sv
// Shared opcodes, direction codes, FSM states and the instruction-word builder
// for the player command scheduler.
package player_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_HEAL    = 4'h1;
  localparam logic [3:0] OP_DAMAGE  = 4'h2;
  localparam logic [3:0] OP_ADD_ATK = 4'h3;
  localparam logic [3:0] OP_SET_ATK = 4'h4;
  localparam logic [3:0] OP_MOVE    = 4'h5;
  localparam logic [3:0] OP_SET_HP  = 4'h6;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT_HP,
    ST_INIT_ATK,
    ST_GAP,
    ST_IDLE,
    ST_ISSUE,
    ST_MOVE
  } state_t;

  // Opcode in [15:12], operand in [11:4], low nibble always zero.
  function automatic logic [15:0] make_instr(input logic [3:0] op, input logic [7:0] operand);
    return {op, operand, 4'h0};
  endfunction

endpackage

// File: rtl/player_hold_timer.sv
// Down-counter that measures one 10 Hz period (MOVE_HOLD clk cycles) for a move.
// done is high while the count is zero; the scheduler only looks at it in MOVE.
module player_hold_timer
  import player_pkg::*;
#(
  parameter int MOVE_HOLD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic done
);

  localparam int W = $clog2(MOVE_HOLD);

  logic [W-1:0] count;

  // Loaded with MOVE_HOLD-1 on the edge the move opcode first appears,
  // so done rises in the last held cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (abort) begin
      count <= '0;
    end else if (start) begin
      count <= W'(MOVE_HOLD - 1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/player_cmd_sched.sv
// Owns the 16-bit instruction bus into the player datapath: runs the post-reset
// init sequence, then arbitrates revive/damage/heal/attack/move requesters.
module player_cmd_sched
  import player_pkg::*;
#(
  parameter int INIT_HP   = 50,
  parameter int INIT_ATK  = 10,
  parameter int MOVE_HOLD = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmg_valid,
  input  logic [7:0]  dmg_amount,
  output logic        dmg_ready,
  input  logic        heal_valid,
  input  logic [7:0]  heal_amount,
  output logic        heal_ready,
  input  logic        atk_valid,
  input  logic        atk_set,
  input  logic [7:0]  atk_value,
  output logic        atk_ready,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  input  logic        revive_valid,
  output logic        revive_ready,
  input  logic        is_death,
  output logic [15:0] instruction,
  output logic        init_done
);

  localparam logic [7:0] HP8  = 8'(INIT_HP);
  localparam logic [7:0] ATK8 = 8'(INIT_ATK);

  state_t      state, state_next;
  logic [15:0] instr_next;
  logic        init_next;
  logic        hold_start, hold_abort, hold_done;

  player_hold_timer #(.MOVE_HOLD(MOVE_HOLD)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .start (hold_start),
    .abort (hold_abort),
    .done  (hold_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT_HP;
      instruction <= '0;
      init_done   <= 1'b0;
    end else begin
      state       <= state_next;
      instruction <= instr_next;
      init_done   <= init_next;
    end
  end

  always_comb begin
    state_next   = state;
    instr_next   = make_instr(OP_NOP, 8'h00);
    init_next    = init_done;
    hold_start   = 1'b0;
    hold_abort   = 1'b0;
    dmg_ready    = 1'b0;
    heal_ready   = 1'b0;
    atk_ready    = 1'b0;
    move_ready   = 1'b0;
    revive_ready = 1'b0;
    case (state)
      ST_INIT_HP: begin
        instr_next = make_instr(OP_SET_HP, HP8);
        state_next = ST_INIT_ATK;
      end
      ST_INIT_ATK: begin
        instr_next = make_instr(OP_SET_ATK, ATK8);
        state_next = ST_GAP;
      end
      ST_GAP: begin
        init_next  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_IDLE: begin
        // While dead only revive may proceed; without death revive is never granted.
        if (!rst) begin
          if (is_death) begin
            if (revive_valid) begin
              revive_ready = 1'b1;
              instr_next   = make_instr(OP_SET_HP, HP8);
              state_next   = ST_ISSUE;
            end
          end else if (dmg_valid) begin
            dmg_ready  = 1'b1;
            instr_next = make_instr(OP_DAMAGE, dmg_amount);
            state_next = ST_ISSUE;
          end else if (heal_valid) begin
            heal_ready = 1'b1;
            instr_next = make_instr(OP_HEAL, heal_amount);
            state_next = ST_ISSUE;
          end else if (atk_valid) begin
            atk_ready  = 1'b1;
            instr_next = make_instr(atk_set ? OP_SET_ATK : OP_ADD_ATK, atk_value);
            state_next = ST_ISSUE;
          end else if (move_valid) begin
            move_ready = 1'b1;
            hold_start = 1'b1;
            instr_next = make_instr(OP_MOVE, {6'b0, move_dir});
            state_next = ST_MOVE;
          end
        end
      end
      ST_ISSUE: begin
        state_next = ST_IDLE;
      end
      ST_MOVE: begin
        if (is_death) begin
          hold_abort = 1'b1;
          state_next = ST_IDLE;
        end else if (hold_done) begin
          state_next = ST_IDLE;
        end else begin
          instr_next = instruction;
        end
      end
      default: begin
        state_next = ST_INIT_HP;
      end
    endcase
  end

endmodule
